// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the fetch front end: default datapath width, the
//   reset and trap addresses, and the fetch sequencer state type.
//   The trap address is only consumed when MISALIGN_TRAP_EN is defined.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  // BOOT : idle cycle right after reset release
  // REQ  : present a fetch request at pc (unless stalled)
  // WAIT : request outstanding, waiting for imemReady
  // HALT : sticky stop, left only through reset
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
//   Combinational next-PC selection plus target alignment handling.
//   Priority: pending (latched) redirect, then a taken redirect this cycle,
//   then the sequential pc+4 supplied by the external adder.
//
//   Build option MISALIGN_TRAP_EN:
//     defined   - a selected target with [1:0] != 0 is replaced by TRAP_VEC and
//                 flagged on misaligned.
//     undefined - the low two bits of a selected target are cleared and
//                 misaligned is constant 0.
//
// Ports
//   pc_plus4    in   XLEN  sequential successor of pc
//   target      in   XLEN  redirect target presented this cycle
//   take        in   1     redirect presented and taken this cycle
//   pend_valid  in   1     a redirect is latched from an earlier cycle
//   pend_target in   XLEN  the latched redirect target
//   next_pc     out  XLEN  selected next program counter
//   misaligned  out  1     selected target was misaligned (trap build only)
// -----------------------------------------------------------------------------
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] target,
  input  logic            take,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] raw_target;
  logic            redirect;

  always_comb begin
    // NOTE: every signal written here gets a default on entry, so no path
    // through the if-tree leaves one unassigned and no latch is inferred.
    raw_target = pend_valid ? pend_target : target;
    redirect   = pend_valid | take;
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (redirect) begin
`ifdef MISALIGN_TRAP_EN
      if (raw_target[1:0] != 2'b00) begin
        misaligned = 1'b1;
        next_pc    = TRAP_VEC;
      end else begin
        next_pc = raw_target;
      end
`else
      // Without the trap, a misaligned target is silently word-aligned.
      next_pc = raw_target & ~XLEN'(3);
`endif
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter register and fetch sequencer. Holds pc, chooses the next
//   pc (sequential pcPlus4 from the external adder, or a branch/jump target)
//   and runs the request/ready handshake with instruction memory.
//
//   Build option MISALIGN_TRAP_EN: when defined, a misaligned selected target
//   redirects pc to TRAP_VEC and pulses misalignTrap for one cycle; when
//   undefined, targets are word-aligned and misalignTrap stays 0.
//
// Parameters
//   XLEN      datapath/address width
//   RESET_PC  pc after reset release
//   TRAP_VEC  misaligned-target trap address (MISALIGN_TRAP_EN builds only)
//
// Ports
//   clk           in   1     rising-edge clock
//   resetN        in   1     asynchronous active-low reset
//   pcPlus4       in   XLEN  pc+4 from the external adder
//   pcSrc         in   1     1 = take pcTarget, qualified by redirectValid
//   pcTarget      in   XLEN  branch/jump target
//   redirectValid in   1     pcSrc/pcTarget meaningful this cycle
//   stall         in   1     hold pc, issue no new request
//   halt          in   1     enter HALT, sticky until reset
//   imemReq       out  1     fetch request, address = pc
//   imemReady     in   1     imem returns the instruction this cycle
//   instrValid    out  1     returned instruction is valid for decode
//   pc            out  XLEN  current program counter
//   misalignTrap  out  1     one-cycle pulse on a trapped misaligned target
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic [XLEN-1:0] pcPlus4,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  input  logic            redirectValid,
  input  logic            stall,
  input  logic            halt,
  output logic            imemReq,
  input  logic            imemReady,
  output logic            instrValid,
  output logic [XLEN-1:0] pc,
  output logic            misalignTrap
);

  fetch_state_e    state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic            trap_q;

  logic            take;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  assign take = redirectValid & pcSrc;

  next_pc_sel #(
    .XLEN(XLEN)
`ifdef MISALIGN_TRAP_EN
    ,
    .TRAP_VEC(TRAP_VEC)
`endif
  ) u_next_pc_sel (
    .pc_plus4   (pcPlus4),
    .target     (pcTarget),
    .take       (take),
    .pend_valid (pend_valid),
    .pend_target(pend_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // The handshake outputs must react to stall, halt and imemReady in the same
  // cycle they are presented, so they are decoded from the state register
  // rather than registered themselves. halt drops both immediately so an
  // in-flight response is discarded.
  assign imemReq    = !halt && ((state == REQ && !stall) || state == WAIT);
  assign instrValid = !halt && state == WAIT && imemReady && !pend_valid && !take;

  // In builds without the trap, misaligned is constant 0, so trap_q never
  // leaves its reset value and the output is effectively tied low.
  assign misalignTrap = trap_q;

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    if (!resetN) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      trap_q      <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      if (halt) begin
        // halt wins over redirect and stall; pc is frozen from here on.
        state      <= HALT;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            // No fetch is outstanding yet, so a redirect lands on pc directly.
            state <= REQ;
            if (take) begin
              pc     <= next_pc;
              trap_q <= misaligned;
            end
          end

          REQ: begin
            if (stall) begin
              // Stalled: no request leaves, but a redirect still moves pc.
              if (take) begin
                pc     <= next_pc;
                trap_q <= misaligned;
              end
            end else begin
              // Request issued at the old pc; a redirect seen now makes its
              // response stale, so remember the target and squash it later.
              state <= WAIT;
              if (take) begin
                pend_valid  <= 1'b1;
                pend_target <= pcTarget;
              end
            end
          end

          WAIT: begin
            if (imemReady) begin
              pc         <= next_pc;
              trap_q     <= misaligned;
              pend_valid <= 1'b0;
              state      <= REQ;
            end else if (take && !pend_valid) begin
              // The first redirect seen while waiting is the one that wins.
              pend_valid  <= 1'b1;
              pend_target <= pcTarget;
            end
          end

          HALT: state <= HALT;

          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule
